soc_riscv_ahb3_slave_mem: RTL and testbench

AMBA3 AHB-Lite slave memory: the responder end of the CPU-to-AHB interface. It gives the bus-interface benches a target that completes transfers and whose behaviour can be checked.
- Accepts NONSEQ/SEQ transfers and stores/returns data with HSIZE byte-lane masking.
- Inserts a programmable number of wait states.
- Issues the two-cycle ERROR response on illegal transfers.

---
 rtl/ahb3lite_pkg.sv | 17 +
 rtl/soc_riscv_ahb3_slave_mem.sv | 139 +++++++++++++
 tb/tb_soc_riscv_ahb3_slave_mem.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AMBA3 AHB-Lite encodings used by the SoC bus slaves and their benches.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/soc_riscv_ahb3_slave_mem.sv
// AHB-Lite slave memory: byte-lane masked storage, programmable wait states and
// the two-cycle ERROR response for oversize, misaligned or out-of-range transfers.
module soc_riscv_ahb3_slave_mem
   import ahb3lite_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int PHYS_ADDR_SIZE = XLEN,
   parameter int MEM_DEPTH      = 256,
   parameter int WAIT_STATES    = 0
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      HSEL,
   input  logic [PHYS_ADDR_SIZE-1:0] HADDR,
   input  logic [XLEN-1:0]           HWDATA,
   input  logic                      HWRITE,
   input  logic [2:0]                HSIZE,
   input  logic [2:0]                HBURST,
   input  logic [3:0]                HPROT,
   input  logic [1:0]                HTRANS,
   input  logic                      HMASTLOCK,
   input  logic                      HREADY,
   output logic                      HREADYOUT,
   output logic                      HRESP,
   output logic [XLEN-1:0]           HRDATA
);

   localparam int NBYTES   = XLEN / 8;
   localparam int ADDR_LSB = $clog2(NBYTES);
   localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [PHYS_ADDR_SIZE-1:0] DEPTH_LIMIT = PHYS_ADDR_SIZE'(MEM_DEPTH);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t              state;
   logic [3:0]          wait_cnt;
   logic                ready_q;
   logic                resp_q;
   logic                dp_write;
   logic [2:0]          dp_size;
   logic [ADDR_LSB-1:0] dp_lane;
   logic [IDX_W-1:0]    dp_idx;
   logic [XLEN-1:0]     mem [MEM_DEPTH];

   logic                      accept;
   logic                      size_ok;
   logic                      align_ok;
   logic                      range_ok;
   logic                      legal;
   logic [ADDR_LSB-1:0]       align_mask;
   logic [PHYS_ADDR_SIZE-1:0] word_addr;
   logic [NBYTES-1:0]         wr_mask;
   logic                      commit;
   logic                      unused_inputs;

   // Little-endian lanes touched by a transfer of 2**size bytes starting at lane.
   function automatic logic [NBYTES-1:0] lane_mask(input logic [ADDR_LSB-1:0] lane,
                                                   input logic [2:0]          size);
      logic [NBYTES-1:0] m;
      int lo;
      int span;
      lo   = int'(lane);
      span = 1 << size;
      for (int i = 0; i < NBYTES; i++)
         m[i] = (i >= lo) && (i < lo + span);
      return m;
   endfunction

   always_comb begin
      accept     = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
      size_ok    = (HSIZE <= 3'(ADDR_LSB));
      align_mask = ADDR_LSB'((32'd1 << HSIZE) - 32'd1);
      align_ok   = (HADDR[ADDR_LSB-1:0] & align_mask) == '0;
      word_addr  = HADDR >> ADDR_LSB;
      range_ok   = word_addr < DEPTH_LIMIT;
      legal      = size_ok && align_ok && range_ok;
   end

   // Wait-state countdown and error handshake take priority; a new transfer is
   // only considered once the current data phase is in its final cycle.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         ready_q  <= 1'b1;
         resp_q   <= HRESP_OKAY;
         wait_cnt <= '0;
         dp_write <= 1'b0;
         dp_size  <= '0;
         dp_lane  <= '0;
         dp_idx   <= '0;
      end else if (state == ST_ERR1) begin
         state   <= ST_ERR2;
         ready_q <= 1'b1;
      end else if (state == ST_DATA && !ready_q) begin
         wait_cnt <= wait_cnt - 4'd1;
         ready_q  <= (wait_cnt == 4'd1);
      end else if (accept) begin
         dp_write <= HWRITE;
         dp_size  <= HSIZE;
         dp_lane  <= HADDR[ADDR_LSB-1:0];
         dp_idx   <= IDX_W'(word_addr);
         if (legal) begin
            state    <= ST_DATA;
            ready_q  <= (WAIT_STATES == 0);
            resp_q   <= HRESP_OKAY;
            wait_cnt <= WAIT_INIT;
         end else begin
            state    <= ST_ERR1;
            ready_q  <= 1'b0;
            resp_q   <= HRESP_ERROR;
            wait_cnt <= '0;
         end
      end else begin
         state   <= ST_IDLE;
         ready_q <= 1'b1;
         resp_q  <= HRESP_OKAY;
      end
   end

   assign wr_mask = lane_mask(dp_lane, dp_size);
   assign commit  = (state == ST_DATA) && ready_q && dp_write;

   // The array has no reset; a write is lost if reset clears the data phase first.
   always_ff @(posedge HCLK) begin
      if (commit) begin
         for (int i = 0; i < NBYTES; i++)
            if (wr_mask[i])
               mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
   end

   assign HREADYOUT = ready_q;
   assign HRESP     = resp_q;
   assign HRDATA    = (state == ST_DATA && !dp_write) ? mem[dp_idx] : '0;

   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

endmodule

// File: tb/tb_soc_riscv_ahb3_slave_mem.sv
// Two slave memories (zero and three wait states) on one AHB-Lite bus with a
// pipelined master, checked against a byte-addressed reference memory.
module tb_soc_riscv_ahb3_slave_mem;
   import ahb3lite_pkg::*;

   localparam int XLEN    = 32;
   localparam int DEPTH   = 256;
   localparam int WS_SLOW = 3;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        hsel, tgt_sel, dp_tgt;
   logic [31:0] haddr, hwdata;
   logic        hwrite, hmastlock;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        rdy0, rdy3, resp0, resp3;
   logic [31:0] rdata0, rdata3;
   logic        hready, hresp;
   logic [31:0] hrdata;

   typedef struct {
      bit          tgt;
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   xfer_t       q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] last_rdata;
   logic [7:0]  mref [2][DEPTH*4];

   always #5 HCLK = ~HCLK;

   soc_riscv_ahb3_slave_mem #(.XLEN(XLEN), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && !tgt_sel), .HADDR(haddr),
      .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready),
      .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

   soc_riscv_ahb3_slave_mem #(.XLEN(XLEN), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS_SLOW)) dut3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && tgt_sel), .HADDR(haddr),
      .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready),
      .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3));

   // Response mux follows whichever slave owns the current data phase.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         dp_tgt <= 1'b0;
      else if (hready)
         dp_tgt <= tgt_sel;
   end

   assign hready = dp_tgt ? rdy3 : rdy0;
   assign hresp  = dp_tgt ? resp3 : resp0;
   assign hrdata = dp_tgt ? rdata3 : rdata0;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic bit legalXfer(input xfer_t x);
      int bytes;
      bytes = 1 << x.size;
      return (x.size <= 3'd2) && (x.addr % bytes == 0) && (x.addr < DEPTH * 4);
   endfunction

   function automatic logic [31:0] modelWord(input bit t, input logic [31:0] addr);
      int base;
      base = int'(addr) & ~3;
      return {mref[t][base+3], mref[t][base+2], mref[t][base+1], mref[t][base]};
   endfunction

   task automatic modelWrite(input xfer_t x);
      int a;
      a = int'(x.addr);
      for (int b = 0; b < (1 << x.size); b++)
         mref[x.tgt][a+b] = x.wdata[8*((a+b)%4) +: 8];
   endtask

   task automatic push(input bit tgt, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
      xfer_t x;
      x.tgt = tgt; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
      q.push_back(x);
   endtask

   task automatic driveIdle();
      hsel      = 1'($urandom_range(0, 1));
      htrans    = $urandom_range(0, 1) ? HTRANS_BUSY : HTRANS_IDLE;
      haddr     = $urandom;
      hwrite    = 1'($urandom_range(0, 1));
      hsize     = 3'($urandom_range(0, 2));
   endtask

   task automatic applyStimulus(input xfer_t x);
      hsel      = 1'b1;
      tgt_sel   = x.tgt;
      haddr     = x.addr;
      hwrite    = x.wr;
      hsize     = x.size;
      htrans    = $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
      hburst    = 3'($urandom_range(0, 7));
      hprot     = 4'($urandom_range(0, 15));
      hmastlock = 1'($urandom_range(0, 1));
   endtask

   // Pipelined master: address phase of the next transfer overlaps the data
   // phase of the current one and is held while the bus is not ready.
   task automatic runQueue();
      int n, nxt, ap, dp, waits, budget;
      bit advance, ok;
      n = q.size(); nxt = 0; ap = -1; dp = -1; waits = 0;
      advance = 1'b1;
      budget = 10 * n + 20;
      while ((nxt < n || ap >= 0 || dp >= 0) && budget > 0) begin
         @(posedge HCLK); #1;
         budget--;
         if (advance) begin
            dp = ap;
            waits = 0;
            if (nxt < n) begin
               applyStimulus(q[nxt]);
               ap = nxt;
               nxt++;
            end else begin
               driveIdle();
               ap = -1;
            end
         end
         hwdata = (dp >= 0) ? q[dp].wdata : $urandom;
         @(negedge HCLK);
         if (dp >= 0) begin
            ok = legalXfer(q[dp]);
            checkOutput("hresp", hresp, ok ? 1'b0 : 1'b1);
            if (hready) begin
               checkOutput("wait_cycles", waits, ok ? (q[dp].tgt ? WS_SLOW : 0) : 1);
               if (ok && !q[dp].wr) begin
                  checkOutput("hrdata", hrdata, modelWord(q[dp].tgt, q[dp].addr));
                  last_rdata = hrdata;
               end else begin
                  checkOutput("hrdata_zero", hrdata, 32'h0);
               end
               if (ok && q[dp].wr)
                  modelWrite(q[dp]);
               dp = -1;
            end else begin
               waits++;
            end
         end else begin
            checkOutput("idle_ready", hready, 1'b1);
            checkOutput("idle_resp", hresp, 1'b0);
         end
         advance = hready;
      end
      checkOutput("queue_drained", (nxt < n || ap >= 0 || dp >= 0), 1'b0);
      q.delete();
   endtask

   task automatic resetDuringWrite();
      logic [31:0] old;
      xfer_t x;
      old = modelWord(1'b1, 32'h80);
      x.tgt = 1'b1; x.wr = 1'b1; x.addr = 32'h80; x.size = HSIZE_WORD; x.wdata = ~old;
      @(posedge HCLK); #1;
      applyStimulus(x);
      @(posedge HCLK); #1;
      driveIdle();
      hsel   = 1'b0;
      hwdata = ~old;
      @(negedge HCLK);
      checkOutput("rst_wait_low", rdy3, 1'b0);
      @(posedge HCLK); #3;
      HRESETn = 1'b0;
      #1;
      checkOutput("rst_async_ready", rdy3, 1'b1);
      checkOutput("rst_async_resp", resp3, 1'b0);
      checkOutput("rst_async_rdata", rdata3, 32'h0);
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      push(1'b1, 1'b0, 32'h80, HSIZE_WORD, 32'h0);
      runQueue();
      checkOutput("rst_word_kept", last_rdata, old);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      HRESETn = 1'b0;
      hsel = 1'b0; tgt_sel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
      hsize = HSIZE_WORD; hburst = '0; hprot = '0; htrans = HTRANS_IDLE; hmastlock = 1'b0;
      #23;
      @(negedge HCLK);
      HRESETn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge HCLK);
         checkOutput("reset_ready0", rdy0, 1'b1);
         checkOutput("reset_ready3", rdy3, 1'b1);
         checkOutput("reset_resp", {resp0, resp3}, 2'b00);
         checkOutput("reset_rdata", {rdata0, rdata3}, 64'h0);
      end

      // Give every word a known value so later reads are fully predictable.
      for (int t = 0; t < 2; t++)
         for (int w = 0; w < DEPTH; w++)
            push(1'(t), 1'b1, 32'(w * 4), HSIZE_WORD, $urandom);
      runQueue();

      push(1'b0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
      push(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
      runQueue();
      checkOutput("b2b_readback", last_rdata, 32'hDEADBEEF);

      push(1'b0, 1'b1, 32'h20, HSIZE_WORD,  32'h00000000);
      push(1'b0, 1'b1, 32'h21, HSIZE_BYTE,  32'h5555AA55);
      push(1'b0, 1'b1, 32'h22, HSIZE_HWORD, 32'h12346666);
      push(1'b0, 1'b0, 32'h20, HSIZE_WORD,  32'h0);
      runQueue();
      checkOutput("byte_lanes", last_rdata, 32'h1234AA00);

      push(1'b1, 1'b1, 32'h44, HSIZE_WORD, 32'hCAFEF00D);
      push(1'b1, 1'b0, 32'h44, HSIZE_WORD, 32'h0);
      runQueue();
      checkOutput("ws3_readback", last_rdata, 32'hCAFEF00D);

      for (int t = 0; t < 2; t++) begin
         push(1'(t), 1'b1, 32'h03, HSIZE_HWORD, 32'hFFFFFFFF);
         push(1'(t), 1'b1, 32'(DEPTH * 4), HSIZE_WORD, 32'hFFFFFFFF);
         push(1'(t), 1'b1, 32'h08, HSIZE_DWORD, 32'hFFFFFFFF);
         push(1'(t), 1'b0, 32'h00, HSIZE_WORD, 32'h0);
      end
      runQueue();

      resetDuringWrite();

      for (int i = 0; i < 300; i++) begin
         int r;
         logic [31:0] a;
         logic [2:0] sz;
         r  = $urandom_range(0, 9);
         if (r < 7)      a = 32'($urandom_range(0, 127));
         else if (r < 9) a = 32'h3F0 + 32'($urandom_range(0, 15));
         else            a = 32'h400 + 32'($urandom_range(0, 15));
         sz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : HSIZE_DWORD;
         if ($urandom_range(0, 3) != 0)
            a = a & ~((32'd1 << sz) - 32'd1);
         push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz, $urandom);
      end
      runQueue();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
